// File: rtl/ddr_rd_pkg.sv
// ----------------------------------------------------------------------------
// ddr_rd_pkg
// Shared definitions for the DDR read-command arbiter (ddr_rd_arb) and its
// outstanding-burst tag queue (ddr_rd_tag_fifo).
//
//   DDR_CMD_RD  MIG user-interface read command encoding
//   DEF_ASTEP   default address increment per beat
//   rd_tag_t    {ch, len} record pushed per granted burst
//   rd_state_t  command FSM states
//
// rd_tag_t is sized for the widest supported configuration (up to 256
// clients, burst-length fields up to 16 bits) because a package typedef
// cannot follow module parameters. The arbiter zero-extends its narrower
// channel index and length into these fields.
// ----------------------------------------------------------------------------
package ddr_rd_pkg;

    localparam logic [2:0] DDR_CMD_RD = 3'b001;
    localparam int         DEF_ASTEP  = 8;

    localparam int TAG_CHW  = 8;
    localparam int TAG_LENW = 16;

    typedef struct packed {
        logic [TAG_CHW-1:0]  ch;
        logic [TAG_LENW-1:0] len;
    } rd_tag_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } rd_state_t;

    // Width of an index that can address n items; never less than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_rd_tag_fifo.sv
// ----------------------------------------------------------------------------
// ddr_rd_tag_fifo
// Synchronous FIFO that holds one tag per issued-but-not-yet-returned burst.
// Head entry is visible combinationally on rdata. Push and pop in the same
// cycle are allowed; occupancy is then unchanged. A push while full or a pop
// while empty is ignored.
//
// Parameters: W     entry width
//             DEPTH number of entries (power of 2, at least 2)
// Ports:
//   clk    in   clock
//   rstn   in   synchronous active-low reset (empties the queue)
//   push   in   write wdata at the tail
//   wdata  in   W-bit entry to push
//   pop    in   discard the head entry
//   rdata  out  head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held
// ----------------------------------------------------------------------------
module ddr_rd_tag_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rd_arb.sv
// ----------------------------------------------------------------------------
// ddr_rd_arb
// N-client DDR read-command arbiter and response router in front of the MIG
// user interface. One client burst is granted at a time, issued beat by beat
// as read commands, and a {ch, len} tag is queued per burst so returning data
// beats (in command order) are steered to the owning client.
//
// Build option: define DDR_RD_ARB_PRIO_EN for fixed priority (lowest channel
// index wins, so channel 0 parameter fetches jump ahead of data reads at burst
// boundaries). Without it, arbitration is round-robin. A burst is never
// preempted once issuing.
//
// Ports:
//   clk_i           in   clock
//   rstn_i          in   synchronous active-low reset
//   req_valid_i     in   [NCH]      per-client burst request
//   req_addr_i      in   [NCH*AW]   per-client start address, client k at [k*AW +: AW]
//   req_len_i       in   [NCH*BLW]  per-client beats minus 1
//   req_ready_o     out  [NCH]      one-hot burst accept (one cycle)
//   ddr_rdy_i       in   MIG command ready
//   ddr_rd_en_o     out  command valid
//   ddr_rd_cmd_o    out  [3]  read command while en is high
//   ddr_rd_addr_o   out  [AW] command address
//   ddr_rd_valid_i  in   read data beat valid
//   ddr_rd_data_i   in   [DW] read data
//   rsp_valid_o     out  [NCH] one-hot beat valid for the owning client
//   rsp_last_o      out  final beat of a burst
//   rsp_data_o      out  [DW] registered read data
//   busy_o          out  issuing, or bursts still outstanding
//   err_o           out  sticky: a beat arrived with no outstanding burst
// ----------------------------------------------------------------------------
module ddr_rd_arb
    import ddr_rd_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DW    = 512,
    parameter int AW    = 30,
    parameter int BLW   = 6,
    parameter int OSD   = 4,
    parameter int ASTEP = DEF_ASTEP
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NCH-1:0]     req_valid_i,
    input  logic [NCH*AW-1:0]  req_addr_i,
    input  logic [NCH*BLW-1:0] req_len_i,
    output logic [NCH-1:0]     req_ready_o,
    input  logic               ddr_rdy_i,
    output logic               ddr_rd_en_o,
    output logic [2:0]         ddr_rd_cmd_o,
    output logic [AW-1:0]      ddr_rd_addr_o,
    input  logic               ddr_rd_valid_i,
    input  logic [DW-1:0]      ddr_rd_data_i,
    output logic [NCH-1:0]     rsp_valid_o,
    output logic               rsp_last_o,
    output logic [DW-1:0]      rsp_data_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int CHW = idx_w(NCH);

    rd_state_t      state;
    rd_state_t      state_nxt;

    logic [AW-1:0]  cmd_addr;
    logic [BLW-1:0] cur_len;
    logic [BLW-1:0] beat_cnt;
    logic [BLW-1:0] rsp_cnt;

    logic           grant_vld;
    logic [CHW-1:0] grant_idx;
    logic           grant;
    logic [AW-1:0]  sel_addr;
    logic [BLW-1:0] sel_len;

    rd_tag_t        push_tag;
    rd_tag_t        head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           last_beat;
    logic           pop;
    logic [NCH-1:0] head_onehot;

`ifndef DDR_RD_ARB_PRIO_EN
    logic [CHW-1:0] ptr;
`endif

    // Channel selection. Only looked at in IDLE; the request protocol keeps
    // addr/len stable while valid, so the combinational select is safe.
`ifdef DDR_RD_ARB_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                grant_vld = 1'b1;
                grant_idx = CHW'(i);
            end
        end
    end
`else
    always_comb begin
        int             c;
        logic [CHW-1:0] cidx;
        grant_vld = 1'b0;
        grant_idx = '0;
        c         = 0;
        cidx      = '0;
        for (int i = 0; i < NCH; i++) begin
            c = int'(ptr) + i;
            if (c >= NCH) begin
                c = c - NCH;
            end
            cidx = CHW'(c);
            if (!grant_vld && req_valid_i[cidx]) begin
                grant_vld = 1'b1;
                grant_idx = cidx;
            end
        end
    end
`endif

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == CHW'(i)) begin
                sel_addr = req_addr_i[i*AW +: AW];
                sel_len  = req_len_i[i*BLW +: BLW];
            end
        end
    end

    // A grant needs room for its tag; without it the client waits.
    assign grant = (state == IDLE) && grant_vld && !fifo_full;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and command outputs. Ready is gated with reset so every
    // output reads 0 while the block is held in reset.
    always_comb begin
        state_nxt     = state;
        req_ready_o   = '0;
        ddr_rd_en_o   = 1'b0;
        ddr_rd_cmd_o  = 3'b000;
        ddr_rd_addr_o = cmd_addr;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    req_ready_o = rstn_i ? (NCH'(1) << grant_idx) : '0;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                ddr_rd_en_o  = 1'b1;
                ddr_rd_cmd_o = DDR_CMD_RD;
                if (ddr_rdy_i && (beat_cnt == cur_len)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst latch and per-beat address advance; address wraps mod 2^AW.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cmd_addr <= '0;
            cur_len  <= '0;
            beat_cnt <= '0;
        end else if (grant) begin
            cmd_addr <= sel_addr;
            cur_len  <= sel_len;
            beat_cnt <= '0;
        end else if ((state == ISSUE) && ddr_rdy_i) begin
            cmd_addr <= cmd_addr + AW'(ASTEP);
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifndef DDR_RD_ARB_PRIO_EN
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign push_tag.ch  = TAG_CHW'(grant_idx);
    assign push_tag.len = TAG_LENW'(sel_len);

    ddr_rd_tag_fifo #(
        .W     ($bits(rd_tag_t)),
        .DEPTH (OSD)
    ) u_tag_fifo (
        .clk   (clk_i),
        .rstn  (rstn_i),
        .push  (grant),
        .wdata (push_tag),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Response steering: the head tag owns every beat until its last one.
    assign last_beat = (head.len == TAG_LENW'(rsp_cnt));
    assign pop       = ddr_rd_valid_i && !fifo_empty && last_beat;

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            head_onehot[i] = (head.ch == TAG_CHW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rsp_valid_o <= '0;
            rsp_last_o  <= 1'b0;
            rsp_data_o  <= '0;
            rsp_cnt     <= '0;
            err_o       <= 1'b0;
        end else begin
            rsp_data_o  <= ddr_rd_data_i;
            rsp_valid_o <= '0;
            rsp_last_o  <= 1'b0;
            if (ddr_rd_valid_i) begin
                if (fifo_empty) begin
                    err_o <= 1'b1;
                end else begin
                    rsp_valid_o <= head_onehot;
                    rsp_last_o  <= last_beat;
                    rsp_cnt     <= last_beat ? '0 : rsp_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o = (state == ISSUE) || !fifo_empty;

endmodule

// File: tb/tb_ddr_rd_arb.sv
// ----------------------------------------------------------------------------
// tb_ddr_rd_arb
// Directed self-checking bench for ddr_rd_arb with NCH=2, OSD=4, ASTEP=8.
// Honours DDR_RD_ARB_PRIO_EN for the expected grant order.
// ----------------------------------------------------------------------------
module tb_ddr_rd_arb;

    localparam int NCH = 2;
    localparam int DW  = 512;
    localparam int AW  = 30;
    localparam int BLW = 6;
    localparam int OSD = 4;

    logic               clk;
    logic               rstn;
    logic [NCH-1:0]     req_valid;
    logic [NCH*AW-1:0]  req_addr;
    logic [NCH*BLW-1:0] req_len;
    logic [NCH-1:0]     req_ready;
    logic               ddr_rdy;
    logic               ddr_rd_en;
    logic [2:0]         ddr_rd_cmd;
    logic [AW-1:0]      ddr_rd_addr;
    logic               ddr_rd_valid;
    logic [DW-1:0]      ddr_rd_data;
    logic [NCH-1:0]     rsp_valid;
    logic               rsp_last;
    logic [DW-1:0]      rsp_data;
    logic               busy;
    logic               err;

    int checks = 0;
    int errors = 0;

    ddr_rd_arb #(
        .NCH (NCH), .DW (DW), .AW (AW), .BLW (BLW), .OSD (OSD), .ASTEP (8)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_len_i      (req_len),
        .req_ready_o    (req_ready),
        .ddr_rdy_i      (ddr_rdy),
        .ddr_rd_en_o    (ddr_rd_en),
        .ddr_rd_cmd_o   (ddr_rd_cmd),
        .ddr_rd_addr_o  (ddr_rd_addr),
        .ddr_rd_valid_i (ddr_rd_valid),
        .ddr_rd_data_i  (ddr_rd_data),
        .rsp_valid_o    (rsp_valid),
        .rsp_last_o     (rsp_last),
        .rsp_data_o     (rsp_data),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [AW-1:0] addr, input logic [BLW-1:0] len);
        req_valid[ch]            = 1'b1;
        req_addr[ch*AW +: AW]    = addr;
        req_len[ch*BLW +: BLW]   = len;
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        req_valid    = '1;
        ddr_rdy      = 1'b1;
        ddr_rd_valid = 1'b0;
        ddr_rd_data  = '0;
        step();
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", req_ready); end
        checks++;
        if (ddr_rd_en !== 1'b0 || ddr_rd_cmd !== 3'b000) begin errors++; $display("[TB] FAIL reset_cmd: got en=%b cmd=%b expected 0/000", ddr_rd_en, ddr_rd_cmd); end
        checks++;
        if (rsp_valid !== 2'b00 || rsp_last !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_status: got rsp_valid=%b last=%b busy=%b err=%b expected all 0", rsp_valid, rsp_last, busy, err);
        end
        rstn      = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
    endtask

    // Wait (bounded) for any ready; returns 1 if ready seen.
    task automatic wait_ready(input string name, output bit ok);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            step();
            n++;
        end
        ok = (req_ready != '0);
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL %s: no req_ready within 20 cycles, got %b", name, req_ready);
        end
    endtask

    task automatic test_single_burst();
        logic [31:0]   word;
        logic [DW-1:0] exp_data;
        test_reset();
        set_req(0, 30'h100, 6'd3);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_grant: got %b expected 01", req_ready); end
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ddr_rd_en !== 1'b1 || ddr_rd_cmd !== 3'b001 || ddr_rd_addr !== 30'(32'h100 + 8*i)) begin
                errors++; $display("[TB] FAIL single_cmd%0d: got en=%b cmd=%b addr=%h expected 1/001/%h", i, ddr_rd_en, ddr_rd_cmd, ddr_rd_addr, 32'h100 + 8*i);
            end
            step();
        end
        checks++;
        if (ddr_rd_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got en=%b busy=%b expected 0/1", ddr_rd_en, busy); end
        for (int j = 0; j < 4; j++) begin
            word         = 32'hA0 + 32'(j);
            exp_data     = {16{word}};
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = exp_data;
            step();
            checks++;
            if (rsp_valid !== 2'b01 || rsp_last !== (j == 3) || rsp_data !== exp_data) begin
                errors++; $display("[TB] FAIL single_beat%0d: got valid=%b last=%b data[31:0]=%h expected 01/%0d/%h", j, rsp_valid, rsp_last, rsp_data[31:0], (j == 3), word);
            end
            checks++;
            if (busy !== (j != 3)) begin errors++; $display("[TB] FAIL single_busy%0d: got %b expected %0d", j, busy, (j != 3)); end
        end
        ddr_rd_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_last !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got valid=%b last=%b expected 00/0", rsp_valid, rsp_last); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_g [4];
        bit ok;
`ifdef DDR_RD_ARB_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        test_reset();
        set_req(0, 30'h1000, 6'd0);
        set_req(1, 30'h2000, 6'd0);
        for (int g = 0; g < 4; g++) begin
            wait_ready("arb_wait", ok);
            if (ok) begin
                checks++;
                if (req_ready !== exp_g[g]) begin errors++; $display("[TB] FAIL arb_grant%0d: got %b expected %b", g, req_ready, exp_g[g]); end
            end
            step();
        end
        req_valid = '0;
        for (int j = 0; j < 4; j++) begin
            ddr_rd_valid = 1'b1;
            step();
            checks++;
            if (rsp_valid !== exp_g[j] || rsp_last !== 1'b1) begin
                errors++; $display("[TB] FAIL arb_route%0d: got valid=%b last=%b expected %b/1", j, rsp_valid, rsp_last, exp_g[j]);
            end
        end
        ddr_rd_valid = 1'b0;
        step();
    endtask

    task automatic test_rdy_stall();
        logic [3:0]    pat;
        logic [AW-1:0] exp_addr [4];
        int            accepted;
        pat      = 4'b1001;
        exp_addr = '{30'h200, 30'h208, 30'h208, 30'h208};
        accepted = 0;
        test_reset();
        set_req(0, 30'h200, 6'd1);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL stall_grant: got %b expected 01", req_ready); end
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            ddr_rdy = pat[3 - i];
            #1;
            checks++;
            if (ddr_rd_en !== 1'b1 || ddr_rd_addr !== exp_addr[i]) begin
                errors++; $display("[TB] FAIL stall_cmd%0d: got en=%b addr=%h expected 1/%h", i, ddr_rd_en, ddr_rd_addr, exp_addr[i]);
            end
            if (ddr_rd_en && ddr_rdy) accepted++;
            step();
        end
        ddr_rdy = 1'b1;
        #1;
        checks++;
        if (ddr_rd_en !== 1'b0 || accepted != 2) begin errors++; $display("[TB] FAIL stall_count: got en=%b accepted=%0d expected 0/2", ddr_rd_en, accepted); end
    endtask

    task automatic test_queue_full();
        bit ok;
        test_reset();
        set_req(0, 30'h400, 6'd0);
        for (int g = 0; g < 4; g++) begin
            wait_ready("full_wait", ok);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL full_block%0d: got %b expected 00", k, req_ready); end
            step();
        end
        ddr_rd_valid = 1'b1;
        step();
        checks++;
        if (rsp_last !== 1'b1 || req_ready !== 2'b01) begin
            errors++; $display("[TB] FAIL full_release: got last=%b ready=%b expected 1/01", rsp_last, req_ready);
        end
        step();
        checks++;
        if (rsp_last !== 1'b1 || ddr_rd_en !== 1'b1) begin
            errors++; $display("[TB] FAIL full_pushpop: got last=%b en=%b expected 1/1", rsp_last, ddr_rd_en);
        end
        ddr_rd_valid = 1'b0;
        req_valid    = '0;
        step();
        for (int j = 0; j < 3; j++) begin
            ddr_rd_valid = 1'b1;
            step();
            checks++;
            if (rsp_last !== 1'b1 || rsp_valid !== 2'b01 || busy !== (j != 2)) begin
                errors++; $display("[TB] FAIL full_drain%0d: got last=%b valid=%b busy=%b expected 1/01/%0d", j, rsp_last, rsp_valid, busy, (j != 2));
            end
        end
        ddr_rd_valid = 1'b0;
        step();
    endtask

    task automatic test_err();
        test_reset();
        ddr_rd_valid = 1'b1;
        step();
        ddr_rd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 2'b00 || err !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got valid=%b err=%b expected 00/1", rsp_valid, err); end
        step();
        step();
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_hold: got %b expected 1", err); end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected 0", err); end
        step();
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_stay_clear: got %b expected 0", err); end
    endtask

    task automatic test_addr_wrap();
        test_reset();
        set_req(1, 30'h3FFFFFF8, 6'd1);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL wrap_grant: got %b expected 10", req_ready); end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (ddr_rd_en !== 1'b1 || ddr_rd_addr !== 30'h3FFFFFF8) begin errors++; $display("[TB] FAIL wrap_cmd0: got en=%b addr=%h expected 1/3ffffff8", ddr_rd_en, ddr_rd_addr); end
        step();
        checks++;
        if (ddr_rd_en !== 1'b1 || ddr_rd_addr !== 30'h0) begin errors++; $display("[TB] FAIL wrap_cmd1: got en=%b addr=%h expected 1/0", ddr_rd_en, ddr_rd_addr); end
        step();
        checks++;
        if (ddr_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end: got en=%b expected 0", ddr_rd_en); end
        for (int j = 0; j < 2; j++) begin
            ddr_rd_valid = 1'b1;
            step();
            checks++;
            if (rsp_valid !== 2'b10 || rsp_last !== (j == 1)) begin
                errors++; $display("[TB] FAIL wrap_beat%0d: got valid=%b last=%b expected 10/%0d", j, rsp_valid, rsp_last, (j == 1));
            end
        end
        ddr_rd_valid = 1'b0;
        step();
    endtask

    initial begin
        rstn         = 1'b0;
        req_valid    = '0;
        req_addr     = '0;
        req_len      = '0;
        ddr_rdy      = 1'b1;
        ddr_rd_valid = 1'b0;
        ddr_rd_data  = '0;
        $display("[TB] start");
        test_reset();
        test_single_burst();
        test_arbitration();
        test_rdy_stall();
        test_queue_full();
        test_err();
        test_addr_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
